// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// lfsr_gen : programmable Fibonacci XNOR LFSR pattern source, ready/valid out.
// Rev 1.0  : optional lock-up recovery under macro LFSR_LOCKUP_DET_EN.
// ============================================================================
module lfsr_gen #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      COUNT_W  = 16,
  parameter logic [WIDTH-1:0] TAPS_RST = 16'hD008,
  parameter logic [WIDTH-1:0] SEED_RST = 16'h0001
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               cfg_wr_i,
  input  logic [1:0]         cfg_addr_i,
  input  logic [WIDTH-1:0]   cfg_data_i,
  output logic [WIDTH-1:0]   cfg_rdata_o,
  output logic               cfg_ack_o,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic               done_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               lockup_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  logic [WIDTH-1:0]   seed_q, stop_q, taps_q;
  logic [1:0]         mode_q;
  logic               ack_q;

  fsm_t               fsm_q, fsm_d;
  logic [WIDTH-1:0]   state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               pulse_q, pulse_d;

  logic               hs;
  logic               stop_hit;
  logic [WIDTH-1:0]   next_state;

  assign hs         = (fsm_q == S_RUN) && out_ready_i;
  assign stop_hit   = mode_q[0] && (state_q == stop_q);
  assign next_state = {state_q[WIDTH-2:0], ~^(state_q & taps_q)};

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      seed_q <= SEED_RST;
      stop_q <= '0;
      taps_q <= TAPS_RST;
      mode_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= cfg_wr_i;
      if (cfg_wr_i) begin
        case (cfg_addr_i)
          2'd0:    seed_q <= cfg_data_i;
          2'd1:    stop_q <= cfg_data_i;
          2'd2:    taps_q <= cfg_data_i;
          default: mode_q <= cfg_data_i[1:0];
        endcase
      end
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr_i)
      2'd0:    cfg_rdata_o = seed_q;
      2'd1:    cfg_rdata_o = stop_q;
      2'd2:    cfg_rdata_o = taps_q;
      default: cfg_rdata_o = {{(WIDTH-2){1'b0}}, mode_q};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef LFSR_LOCKUP_DET_EN
  logic lockup_q, lockup_d;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) lockup_q <= 1'b0;
    else           lockup_q <= lockup_d;
  end

  assign lockup_o = lockup_q;
`else
  assign lockup_o = 1'b0;
`endif

  // Priority: abort, then start, then a downstream handshake.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
    lockup_d = lockup_q;
`endif
    if (abort_i) begin
      fsm_d = S_IDLE;
    end else if (start_i) begin
      fsm_d   = S_RUN;
      state_d = seed_q;
      count_d = '0;
`ifdef LFSR_LOCKUP_DET_EN
      lockup_d = 1'b0;
`endif
    end else if (hs) begin
      if (count_q != {COUNT_W{1'b1}}) count_d = count_q + 1'b1;
      if (stop_hit) begin
        if (mode_q[1]) begin
          state_d = seed_q;
          pulse_d = 1'b1;
        end else begin
          fsm_d = S_DONE;
        end
      end
`ifdef LFSR_LOCKUP_DET_EN
      else if (state_q == {WIDTH{1'b1}}) begin
        state_d  = '0;
        lockup_d = 1'b1;
      end
`endif
      else begin
        state_d = next_state;
      end
    end
  end

  assign out_valid_o = (fsm_q == S_RUN);
  assign out_data_o  = state_q;
  assign done_o      = (fsm_q == S_DONE) || pulse_q;
  assign count_o     = count_q;
  assign cfg_ack_o   = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
// tb_lfsr_gen : self-checking bench for lfsr_gen against a word-level model.
// Rev 1.0
// ============================================================================
module tb_lfsr_gen;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          nreset, cfg_wr, start, abort, ready;
  logic [1:0]    addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata, out_data;
  logic          ack, out_valid, done, lockup;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk_i(clk), .nreset_i(nreset),
    .cfg_wr_i(cfg_wr), .cfg_addr_i(addr), .cfg_data_i(wdata),
    .cfg_rdata_o(rdata), .cfg_ack_o(ack),
    .start_i(start), .abort_i(abort),
    .out_valid_o(out_valid), .out_ready_i(ready), .out_data_o(out_data),
    .done_o(done), .count_o(count), .lockup_o(lockup)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Word-level reference: phase 0 idle, 1 running, 2 stopped.
  logic [W-1:0] m_seed, m_stop, m_taps, m_state;
  logic [1:0]   m_mode;
  int           m_phase;
  int unsigned  m_count;
  bit           m_pulse, m_lock, m_ack;

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s, input logic [W-1:0] t);
    int ones;
    ones = $countones(s & t);
    return {s[W-2:0], (ones % 2 == 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic model_reset();
    m_seed = 16'h0001; m_stop = '0; m_taps = 16'hD008; m_mode = '0;
    m_phase = 0; m_state = '0; m_count = 0; m_pulse = 0; m_lock = 0; m_ack = 0;
  endtask

  task automatic model_edge();
    bit pulse_n;
    pulse_n = 0;
    if (abort) begin
      m_phase = 0;
    end else if (start) begin
      m_phase = 1; m_state = m_seed; m_count = 0; m_lock = 0;
    end else if (m_phase == 1 && ready) begin
      if (m_count < (2**CW - 1)) m_count++;
      if (m_mode[0] && m_state == m_stop) begin
        if (m_mode[1]) begin m_state = m_seed; pulse_n = 1; end
        else m_phase = 2;
      end
`ifdef LFSR_LOCKUP_DET_EN
      else if (m_state == 16'hFFFF) begin m_state = '0; m_lock = 1; end
`endif
      else m_state = lfsr_next(m_state, m_taps);
    end
    m_pulse = pulse_n;
    m_ack   = cfg_wr;
    if (cfg_wr) begin
      case (addr)
        2'd0: m_seed = wdata;
        2'd1: m_stop = wdata;
        2'd2: m_taps = wdata;
        2'd3: m_mode = wdata[1:0];
      endcase
    end
  endtask

  function automatic logic [W-1:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return m_seed;
      2'd1:    return m_stop;
      2'd2:    return m_taps;
      default: return {14'd0, m_mode};
    endcase
  endfunction

  task automatic compare_all();
    check("valid",  out_valid, (m_phase == 1));
    check("data",   out_data,  m_state);
    check("done",   done,      (m_phase == 2) || m_pulse);
    check("count",  count,     m_count);
    check("lockup", lockup,    m_lock);
    check("ack",    ack,       m_ack);
    check("rdata",  rdata,     model_rdata(addr));
  endtask

  task automatic cycle(input bit wr, input bit [1:0] a, input logic [W-1:0] d,
                       input bit st, input bit ab, input bit rdy);
    @(negedge clk);
    cfg_wr = wr; addr = a; wdata = d; start = st; abort = ab; ready = rdy;
    @(posedge clk);
    if (nreset) model_edge(); else model_reset();
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 2'd0, '0, 0, 0, rdy);
  endtask

  logic [W-1:0]  held_data;
  logic [CW-1:0] held_count;

  initial begin
    nreset = 0; cfg_wr = 0; addr = 0; wdata = 0; start = 0; abort = 0; ready = 0;
    model_reset();
    idle_cycles(2, 0);
    nreset = 1;
    cycle(0, 2'd2, '0, 0, 0, 0);
    check("rst_taps", rdata, 16'hD008);

    // free-run
    cycle(0, 2'd0, '0, 1, 0, 1);
    check("free_seed", out_data, 16'h0001);
    idle_cycles(3, 1);
    check("free_000F", out_data, 16'h000F);
    idle_cycles(1, 1);
    check("free_count", count, 4);

    // stop
    cycle(1, 2'd1, 16'h0007, 0, 0, 0);
    cycle(1, 2'd3, 16'h0001, 0, 0, 0);
    cycle(0, 2'd0, '0, 1, 0, 1);
    idle_cycles(2, 1);
    check("stop_0007", out_data, 16'h0007);
    idle_cycles(1, 1);
    check("stop_done",  done, 1);
    check("stop_valid", out_valid, 0);
    check("stop_count", count, 3);
    cycle(0, 2'd0, '0, 1, 0, 0);
    check("restart_done", done, 0);
    check("restart_data", out_data, 16'h0001);

    // reload
    cycle(1, 2'd1, 16'h0003, 0, 0, 0);
    cycle(1, 2'd3, 16'h0003, 1, 0, 0);
    idle_cycles(2, 1);
    check("reload_pulse", done, 1);
    check("reload_seed",  out_data, 16'h0001);
    idle_cycles(1, 1);
    check("reload_pulse_end", done, 0);
    idle_cycles(4, 1);

    // backpressure
    cycle(1, 2'd3, 16'h0000, 1, 0, 1);
    idle_cycles(3, 1);
    held_data = out_data; held_count = count;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 2'd0, '0, 0, 0, 0);
      check("bp_data",  out_data, held_data);
      check("bp_count", count, held_count);
    end
    idle_cycles(3, 1);

    // lock-up
    cycle(1, 2'd0, 16'hFFFF, 0, 0, 0);
    cycle(0, 2'd0, '0, 1, 0, 1);
    idle_cycles(2, 1);
`ifdef LFSR_LOCKUP_DET_EN
    check("lock_data", out_data, 16'h0001);
    check("lock_flag", lockup, 1);
`else
    check("lock_data", out_data, 16'hFFFF);
    check("lock_flag", lockup, 0);
`endif

    // mid-run reset
    cycle(1, 2'd0, 16'h0001, 1, 0, 1);
    idle_cycles(2, 1);
    nreset = 0;
    cycle(0, 2'd2, '0, 0, 0, 1);
    nreset = 1;
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_taps2", rdata, 16'hD008);

    // abort beats start
    cycle(0, 2'd0, '0, 1, 1, 1);
    check("abort_valid", out_valid, 0);

    // config write ack and readback
    cycle(1, 2'd1, 16'h1234, 0, 0, 0);
    check("cfg_ack",   ack, 1);
    check("cfg_rdata", rdata, 16'h1234);
    idle_cycles(1, 0);
    check("cfg_ack_low", ack, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit wr, st, ab, rdy;
      bit [1:0] a;
      logic [W-1:0] d;
      wr  = ($urandom_range(0, 7) == 0);
      a   = 2'($urandom_range(0, 3));
      d   = 16'($urandom);
      if (a == 2'd1 && $urandom_range(0, 1) == 1) d = m_state;
      if (a == 2'd0 && $urandom_range(0, 3) == 0) d = 16'hFFFF;
      st  = ($urandom_range(0, 24) == 0);
      ab  = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cycle(wr, a, d, st, ab, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci XNOR LFSR pattern source. Runtime-programmable seed, stop value, tap mask and mode. Delivers one word per accepted ready/valid handshake to downstream pixel/test logic. Successor to the fixed-tap, fixed-width generator: adds a programmable polynomial, backpressure, an auto-reload mode, a word counter and optional lock-up recovery.

## Interface

**Parameters**

- `WIDTH`, 16: LFSR and data width, 4..32.
- `COUNT_W`, 16: width of the accepted-word counter.
- `TAPS_RST`, 16'hD008: reset value of the tap mask. Bit i set means state bit i feeds the XNOR.
- `SEED_RST`, 16'h0001: reset value of the seed register.

**Ports** (clock and reset first)

- `clk_i`: in, 1. Single clock; all logic on the rising edge.
- `nreset_i`: in, 1. Reset is synchronous and active-low.
- `cfg_wr_i`: in, 1. Config write strobe.
- `cfg_addr_i`: in, 2. Register select: 0 seed, 1 stop, 2 taps, 3 mode.
- `cfg_data_i`: in, WIDTH. Write data.
- `cfg_rdata_o`: out, WIDTH. Combinational read of the register at `cfg_addr_i`. Mode reads zero-extended.
- `cfg_ack_o`: out, 1. Registered copy of `cfg_wr_i`.
- `start_i`: in, 1. Load the seed, clear the counter, enter RUN.
- `abort_i`: in, 1. Return to IDLE.
- `out_valid_o`: out, 1. Output word valid.
- `out_ready_i`: in, 1. Downstream accepts the word.
- `out_data_o`: out, WIDTH. Current LFSR state.
- `done_o`: out, 1. Stop value reached.
- `count_o`: out, COUNT_W. Accepted words since the last start; saturates at all-ones.
- `lockup_o`: out, 1. Sticky lock-up flag. Tied 0 when the feature is compiled out.

## Operation

**Registers**

- seed, stop, taps, mode(1:0).
- mode bit0 STOP_EN: compare the accepted word against stop.
- mode bit1 RELOAD: on a stop match, reload the seed and keep running.
- Writes are accepted in any state and take effect the next cycle.
- A taps write during RUN affects the next step.
- A seed write affects only the next load.

**Next state**

- fb = ~^(state & taps).
- next = {state[WIDTH-2:0], fb}.

**FSM states:** IDLE, RUN, DONE.

- IDLE: `out_valid_o`=0. `start_i` loads state←seed, count←0, goes to RUN.
- RUN: `out_valid_o`=1, `out_data_o`=state. On handshake (valid & ready), count increments (saturating) and:
  - STOP_EN=1 and state==stop, RELOAD=0: go to DONE; state holds.
  - STOP_EN=1 and state==stop, RELOAD=1: state←seed; `done_o` pulses for one cycle; stay in RUN.
  - Otherwise: state←next.
- Without a handshake, state and data hold. `out_data_o` must not change while valid is high and ready is low.
- DONE: `done_o`=1, `out_valid_o`=0, state held. `start_i` restarts.

**Precedence**

- `abort_i` beats `start_i` beats handshake.
- `start_i` in RUN or DONE performs a full restart: seed reload, count clear, `done_o` clear, `lockup_o` clear.
- A seed equal to stop with STOP_EN=1 emits exactly one word, then stops.

**Reset** (`nreset_i`=0 at a clock edge, including mid-run)

- Registers return to: seed=SEED_RST, stop=0, taps=TAPS_RST, mode=0.
- FSM goes to IDLE; state=0.
- All outputs return to 0: `out_valid_o`, `done_o`, `count_o`, `lockup_o`, `cfg_ack_o`.
- `cfg_rdata_o` then shows reset values.

## Timing

- `start_i` at edge N: `out_valid_o`=1 with data=seed from N+1.
- Handshake at edge N: the new word is visible at N+1. Sustained throughput is 1 word/cycle.
- Final handshake at edge N (RELOAD=0): `done_o`=1 and `out_valid_o`=0 from N+1.
- Final handshake at edge N (RELOAD=1): `done_o`=1 for cycle N+1 only; seed presented at N+1.
- `cfg_ack_o` is high the cycle after `cfg_wr_i`.
- A `cfg_wr_i` to stop at the same edge as a handshake: the compare at that edge uses the old value.
- `count_o` updates in the same cycle as data.

## Configuration

Macro: `LFSR_LOCKUP_DET_EN`.

- **Defined:** a handshake on state == all-ones (the XNOR lock-up state) loads state←0 instead of next and sets `lockup_o` (sticky until start or reset). The stop compare still applies first.
- **Undefined:** no detection; all-ones repeats forever; `lockup_o` is tied 0.

## Test plan

- **Free-run.** WIDTH=16, taps=0xD008, seed=0x0001, mode=0, ready=1.
  - Required: outputs 0x0001, 0x0003, 0x0007, 0x000F on consecutive cycles; count=4.
- **Stop.** stop=0x0007, mode=1.
  - Required: outputs 0x0001, 0x0003, 0x0007, then valid=0, `done_o`=1, count=3.
  - Then `start_i`: `done_o` clears and 0x0001 is re-emitted.
- **Reload.** mode=3, stop=0x0003.
  - Required: outputs 0x0001, 0x0003, 0x0001, 0x0003…; `done_o` pulses one cycle after each 0x0003 handshake.
- **Backpressure.** Hold ready=0 for 5 cycles mid-stream.
  - Required: data and count stable throughout; sequence resumes unchanged when ready returns.
- **Lock-up.** seed=0xFFFF, taps=0xD008.
  - Macro defined: 0xFFFF, 0x0000, 0x0001; `lockup_o`=1.
  - Macro undefined: 0xFFFF repeated; `lockup_o`=0.
- **Reset, abort and config.**
  - `nreset_i` low for one edge mid-run: all outputs 0; `cfg_rdata_o` at addr 2 reads 0xD008.
  - `abort_i` together with `start_i`: IDLE.
  - `cfg_wr_i` at addr 1: `cfg_ack_o` high one cycle later; readback matches.
